// File: rtl/ucode_useq.sv
// Microcode next-address sequencer: IDLE/RUN/FAULT control, conditional
// branching and a small LIFO return-address stack for CALL/RET.
module ucode_useq #(
  parameter int unsigned AW     = 9,
  parameter int unsigned NCOND  = 8,
  parameter int unsigned SDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic                     start,
  input  logic [AW-1:0]            entry_addr,
  input  logic                     stall,
  input  logic                     kill,
  input  logic [NCOND-1:0]         cond,
  input  logic [2:0]               u_op,
  input  logic [$clog2(NCOND)-1:0] u_csel,
  input  logic                     u_cpol,
  input  logic [AW-1:0]            u_target,
  output logic [AW-1:0]            rom_addr,
  output logic                     busy,
  output logic                     u_last,
  output logic                     u_done,
  output logic                     fault,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  localparam int unsigned DW = $clog2(SDEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BR   = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_DONE = 3'd5
  } op_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [AW-1:0]   stk_q [SDEPTH];
  logic [AW-1:0]   stk_d [SDEPTH];
  logic            u_done_q, u_done_d;
  logic            stk_ovf_q, stk_ovf_d;
  logic            stk_unf_q, stk_unf_d;

  logic [AW-1:0]   addr_inc;
  logic [AW-1:0]   pop_addr;
  logic            stk_full;
  logic            stk_empty;
  logic            br_taken;

  assign addr_inc  = rom_addr_q + AW'(1);
  assign stk_full  = (32'(depth_q) == SDEPTH);
  assign stk_empty = (depth_q == '0);
  assign br_taken  = cond[u_csel] ^ u_cpol;

  // Top of stack selected by compare rather than a computed index so the
  // index width never has to match the depth counter width.
  always_comb begin
    pop_addr = '0;
    for (int unsigned i = 0; i < SDEPTH; i++) begin
      if (i + 1 == 32'(depth_q)) pop_addr = stk_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    depth_d    = depth_q;
    stk_d      = stk_q;
    u_done_d   = 1'b0;
    stk_ovf_d  = stk_ovf_q;
    stk_unf_d  = stk_unf_q;

    if (kill) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      depth_d    = '0;
      stk_ovf_d  = 1'b0;
      stk_unf_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_RUN;
            rom_addr_d = entry_addr;
          end else begin
            rom_addr_d = '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            case (op_e'(u_op))
              OP_JMP: rom_addr_d = u_target;
              OP_BR:  rom_addr_d = br_taken ? u_target : addr_inc;
              OP_CALL: begin
                if (stk_full) begin
                  stk_ovf_d = 1'b1;
                  state_d   = S_FAULT;
                end else begin
                  for (int unsigned i = 0; i < SDEPTH; i++) begin
                    if (i == 32'(depth_q)) stk_d[i] = addr_inc;
                  end
                  depth_d    = depth_q + DW'(1);
                  rom_addr_d = u_target;
                end
              end
              OP_RET: begin
                if (stk_empty) begin
                  stk_unf_d = 1'b1;
                  state_d   = S_FAULT;
                end else begin
                  depth_d    = depth_q - DW'(1);
                  rom_addr_d = pop_addr;
                end
              end
              OP_DONE: begin
                u_done_d = 1'b1;
                depth_d  = '0;
                if (start) begin
                  state_d    = S_RUN;
                  rom_addr_d = entry_addr;
                end else begin
                  state_d    = S_IDLE;
                  rom_addr_d = '0;
                end
              end
              default: rom_addr_d = addr_inc;
            endcase
          end
        end
        default: begin
          state_d = S_FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      depth_q    <= '0;
      u_done_q   <= 1'b0;
      stk_ovf_q  <= 1'b0;
      stk_unf_q  <= 1'b0;
      for (int unsigned i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      depth_q    <= depth_d;
      u_done_q   <= u_done_d;
      stk_ovf_q  <= stk_ovf_d;
      stk_unf_q  <= stk_unf_d;
      stk_q      <= stk_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = (state_q == S_RUN);
  assign fault    = (state_q == S_FAULT);
  assign u_done   = u_done_q;
  assign stk_ovf  = stk_ovf_q;
  assign stk_unf  = stk_unf_q;
  assign u_last   = (state_q == S_RUN) && (u_op == OP_DONE) && !stall && !kill;

endmodule
